uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter: start, 8 data bits LSB first, stop; frames run back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data[7] and the stop bit.
module uart_tx #(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       pi_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_CNT_MAX - 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          line_busy_q;
  logic          fifo_empty, fifo_full, push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // Extra pointer bit tells full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = pi_flag && !fifo_full;
  assign bit_end    = (baud_cnt_q == '0);

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= pi_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    if (state_q != IDLE) baud_cnt_d = bit_end ? BAUD_LOAD : baud_cnt_q - BW'(1);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      baud_cnt_d = BAUD_LOAD;
      shift_d    = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      line_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      line_busy_q <= (state_q != IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)  parity_q <= 1'b0;
    else if (pop) parity_q <= ^mem_q[rd_ptr_q[AW-1:0]];
  end
`endif

  assign pi_ready = !fifo_full;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty || line_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a mid-bit line decoder feeds a byte scoreboard; timing checked by cycle counts.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CLK_FREQ = 70;
  localparam int UART_BPS = 10;
  localparam int B        = CLK_FREQ / UART_BPS;
  localparam int DEPTH    = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * B;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic       pi_ready, tx, tx_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  uart_tx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pi_data (pi_data),
    .pi_flag (pi_flag),
    .pi_ready(pi_ready),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line decoder: a frame starts on the first low cycle, each bit is sampled at its middle.
  logic [NB-1:0] fbits;
  logic [7:0]    rxd;
  logic          last_par = 1'b0;
  bit            in_frame = 1'b0;
  int            off = 0;

  initial forever begin
    @(negedge sys_clk);
    if (sys_rst) in_frame = 1'b0;
    else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        off = 0;
      end
    end else off++;
    if (in_frame && !sys_rst) begin
      if (off % B == B / 2) fbits[off / B] = tx;
      if (off == FRAME - 1) begin
        in_frame = 1'b0;
        rxd = fbits[8:1];
        check("start_bit", fbits[0], 1'b0);
        check("stop_bit", fbits[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
        last_par = fbits[9];
        check("parity_bit", fbits[9], ^rxd);
`endif
        rx_q.push_back(rxd);
      end
    end
  end

  task automatic put(input logic [7:0] d);
    @(negedge sys_clk);
    pi_flag = 1'b1;
    pi_data = d;
  endtask

  task automatic idle_cycle();
    @(negedge sys_clk);
    pi_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (tx_busy !== 1'b0 && n < max) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_idle"}, tx_busy, 1'b0);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask

  // Write-edge to tx_busy-low spans the frame plus the 2-cycle start latency.
  task automatic single_byte(input string tag, input logic [7:0] d);
    int c0;
    put(d);
    exp_q.push_back(d);
    idle_cycle();
    c0 = cyc;
    check({tag, "_lat0"}, tx, 1'b1);
    @(negedge sys_clk);
    check({tag, "_lat1"}, tx, 1'b1);
    @(negedge sys_clk);
    check({tag, "_lat2"}, tx, 1'b0);
    wait_idle(tag, FRAME + 20);
    check({tag, "_len"}, cyc - c0, FRAME + 2);
    compare_queues(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [8];
    logic [7:0] d, a5;
    int c0, lows, len, gap;

    repeat (3) @(negedge sys_clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", pi_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    single_byte("single", 8'h0E);

    burst = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0E, 8'h05, 8'h06, 8'h0C};
    c0 = 0;
    for (int i = 0; i < 8; i++) begin
      put(burst[i]);
      exp_q.push_back(burst[i]);
      if (i == 1) c0 = cyc;
    end
    idle_cycle();
    wait_idle("burst", 8 * FRAME + 40);
    check("burst_len", cyc - c0, 8 * FRAME + 2);
    compare_queues("burst");

    // Ten back-to-back writes: 8 buffered plus 1 already popped, the tenth is dropped.
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (i > 0) check("ovf_ready", pi_ready, (i < 9) ? 1'b1 : 1'b0);
      d = 8'($urandom);
      pi_flag = 1'b1;
      pi_data = d;
      if (i < 9) exp_q.push_back(d);
    end
    @(negedge sys_clk);
    check("ovf_ready", pi_ready, 1'b0);
    pi_flag = 1'b0;
    wait_idle("ovf", 12 * FRAME);
    compare_queues("ovf");

    a5 = 8'hA5;
    put(a5);
    put(8'h3C);
    put(8'h96);
    idle_cycle();
    lows = 0;
    while (tx !== 1'b0 && lows < 20) begin
      @(negedge sys_clk);
      lows++;
    end
    check("rst_mid_start", tx, 1'b0);
    repeat (4 * B + 2) @(negedge sys_clk);
    check("rst_mid_bit3", tx, a5[3]);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", tx_busy, 1'b0);
    check("rst_mid_ready", pi_ready, 1'b1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_mid_quiet", lows, 0);
    check("rst_mid_rx", rx_q.size(), 0);
    check("rst_mid_idle", tx_busy, 1'b0);
    rx_q.delete();
    exp_q.delete();

`ifdef UART_TX_PARITY_EN
    single_byte("par07", 8'h07);
    check("par07_value", last_par, 1'b1);
    single_byte("par03", 8'h03);
    check("par03_value", last_par, 1'b0);
`endif

    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      put(d);
      exp_q.push_back(d);
      idle_cycle();
      wait_idle("wrap", FRAME + 20);
    end
    compare_queues("wrap");

    for (int b = 0; b < 10; b++) begin
      len = $urandom_range(DEPTH, 1);
      for (int i = 0; i < len; i++) begin
        gap = $urandom_range(2, 0);
        repeat (gap) idle_cycle();
        d = 8'($urandom);
        put(d);
        exp_q.push_back(d);
      end
      idle_cycle();
      wait_idle("rand", DEPTH * FRAME + 40);
      compare_queues("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
